// File: rtl/store_drain.sv
// Store-queue drain: takes the committed head store and issues it to the dcache or MMIO port.
// Optional response timeout is compiled in with `define STORE_DRAIN_TIMEOUT_EN.
module store_drain #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        head_ready_to_deq,
    input  logic        head_mmio,
    input  logic [63:0] head_store_addr,
    input  logic [63:0] head_store_data,
    input  logic [63:0] head_store_mask,
    input  logic [3:0]  head_store_ls_size,
    output logic        head_issuing,
    output logic        dcache_req_valid,
    input  logic        dcache_req_ready,
    output logic [63:0] dcache_req_addr,
    output logic [63:0] dcache_req_data,
    output logic [63:0] dcache_req_mask,
    output logic [3:0]  dcache_req_size,
    input  logic        dcache_resp_valid,
    output logic        mmio_req_valid,
    input  logic        mmio_req_ready,
    input  logic        mmio_resp_valid,
    output logic        drain_busy,
    output logic        drain_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] data_q, data_d;
    logic [63:0] mask_q, mask_d;
    logic [3:0]  size_q, size_d;
    logic        mmio_q, mmio_d;
    logic        dreq_q, dreq_d;
    logic        mreq_q, mreq_d;
    logic        issue_q, issue_d;
    logic        req_accept;
    logic        resp_hit;

`ifdef STORE_DRAIN_TIMEOUT_EN
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       err_q, err_d;
`endif

    // Only the port selected by the latched mmio bit may complete a phase.
    assign req_accept = mmio_q ? mmio_req_ready  : dcache_req_ready;
    assign resp_hit   = mmio_q ? mmio_resp_valid : dcache_resp_valid;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        size_d  = size_q;
        mmio_d  = mmio_q;
        dreq_d  = dreq_q;
        mreq_d  = mreq_q;
        issue_d = 1'b0;
`ifdef STORE_DRAIN_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                // issue_q high means the head still shows the entry just freed.
                if (head_ready_to_deq && !issue_q) begin
                    addr_d  = head_store_addr;
                    data_d  = head_store_data;
                    mask_d  = head_store_mask;
                    size_d  = head_store_ls_size;
                    mmio_d  = head_mmio;
                    dreq_d  = !head_mmio;
                    mreq_d  = head_mmio;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_accept) begin
                    dreq_d  = 1'b0;
                    mreq_d  = 1'b0;
                    state_d = WAIT_RESP;
`ifdef STORE_DRAIN_TIMEOUT_EN
                    tmo_cnt_d = 8'd0;
`endif
                end
            end
            WAIT_RESP: begin
`ifdef STORE_DRAIN_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 8'd1;
`endif
                if (resp_hit) begin
                    issue_d = 1'b1;
                    state_d = IDLE;
                end
`ifdef STORE_DRAIN_TIMEOUT_EN
                else if (tmo_cnt_d == TMO_LIMIT) begin
                    err_d   = 1'b1;
                    issue_d = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            mask_q  <= '0;
            size_q  <= '0;
            mmio_q  <= 1'b0;
            dreq_q  <= 1'b0;
            mreq_q  <= 1'b0;
            issue_q <= 1'b0;
`ifdef STORE_DRAIN_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            size_q  <= size_d;
            mmio_q  <= mmio_d;
            dreq_q  <= dreq_d;
            mreq_q  <= mreq_d;
            issue_q <= issue_d;
`ifdef STORE_DRAIN_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign head_issuing     = issue_q;
    assign dcache_req_valid = dreq_q;
    assign mmio_req_valid   = mreq_q;
    assign dcache_req_addr  = addr_q;
    assign dcache_req_data  = data_q;
    assign dcache_req_mask  = mask_q;
    assign dcache_req_size  = size_q;
    assign drain_busy       = (state_q != IDLE);

`ifdef STORE_DRAIN_TIMEOUT_EN
    assign drain_err = err_q;
`else
    assign drain_err = 1'b0;
`endif

endmodule

// File: tb/tb_store_drain.sv
// Directed bench for store_drain: payload scoreboard on request handshakes plus
// cycle-accurate checks of valids, head_issuing, reset and timeout behaviour.
module tb_store_drain;

    localparam int W = 197;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        head_ready_to_deq = 1'b0;
    logic        head_mmio = 1'b0;
    logic [63:0] head_store_addr = '0;
    logic [63:0] head_store_data = '0;
    logic [63:0] head_store_mask = '0;
    logic [3:0]  head_store_ls_size = '0;
    logic        head_issuing;
    logic        dcache_req_valid;
    logic        dcache_req_ready = 1'b0;
    logic [63:0] dcache_req_addr;
    logic [63:0] dcache_req_data;
    logic [63:0] dcache_req_mask;
    logic [3:0]  dcache_req_size;
    logic        dcache_resp_valid = 1'b0;
    logic        mmio_req_valid;
    logic        mmio_req_ready = 1'b0;
    logic        mmio_resp_valid = 1'b0;
    logic        drain_busy;
    logic        drain_err;

    int checks = 0;
    int failures = 0;
    int issue_cnt = 0;
    int exp_issues = 0;
    logic [W-1:0] exp_q[$];

`ifdef STORE_DRAIN_TIMEOUT_EN
    store_drain #(.TIMEOUT_CYCLES(8)) dut (
`else
    store_drain dut (
`endif
        .clock              (clock),
        .reset              (reset),
        .head_ready_to_deq  (head_ready_to_deq),
        .head_mmio          (head_mmio),
        .head_store_addr    (head_store_addr),
        .head_store_data    (head_store_data),
        .head_store_mask    (head_store_mask),
        .head_store_ls_size (head_store_ls_size),
        .head_issuing       (head_issuing),
        .dcache_req_valid   (dcache_req_valid),
        .dcache_req_ready   (dcache_req_ready),
        .dcache_req_addr    (dcache_req_addr),
        .dcache_req_data    (dcache_req_data),
        .dcache_req_mask    (dcache_req_mask),
        .dcache_req_size    (dcache_req_size),
        .dcache_resp_valid  (dcache_resp_valid),
        .mmio_req_valid     (mmio_req_valid),
        .mmio_req_ready     (mmio_req_ready),
        .mmio_resp_valid    (mmio_resp_valid),
        .drain_busy         (drain_busy),
        .drain_err          (drain_err)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- check helper ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic mmio, input logic [63:0] a, input logic [63:0] d,
                           input logic [63:0] m, input logic [3:0] s);
        head_ready_to_deq  = 1'b1;
        head_mmio          = mmio;
        head_store_addr    = a;
        head_store_data    = d;
        head_store_mask    = m;
        head_store_ls_size = s;
        exp_q.push_back({mmio, s, a, d, m});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [W-1:0] obs;
        logic [W-1:0] exp;
        if (!reset) begin
            checks++;
            assert ((dcache_req_valid && mmio_req_valid) === 1'b0) else begin
                failures++;
                $error("FAIL both_valid observed=1 expected=0");
            end
            if ((dcache_req_valid && dcache_req_ready) || (mmio_req_valid && mmio_req_ready)) begin
                obs = {mmio_req_valid, dcache_req_size, dcache_req_addr, dcache_req_data, dcache_req_mask};
                exp = '0;
                if (exp_q.size() > 0) exp = exp_q.pop_front();
                checks++;
                assert (obs === exp) else begin
                    failures++;
                    $error("FAIL sb_payload observed=%h expected=%h", obs, exp);
                end
            end
            if (head_issuing) issue_cnt++;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int pulses;
        int p1;
        int p2;
        int idx;
        int pulse_cyc;

        // Reset state
        next_cycle();
        @(negedge clock);
        chk("rst_busy", 64'(drain_busy), 64'd0);
        chk("rst_issue", 64'(head_issuing), 64'd0);
        chk("rst_dreq", 64'(dcache_req_valid), 64'd0);
        chk("rst_mreq", 64'(mmio_req_valid), 64'd0);
        chk("rst_addr", dcache_req_addr, 64'd0);
        chk("rst_err", 64'(drain_err), 64'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Cacheable store, ready and response one cycle each
        present(1'b0, 64'h8000_0010, 64'hDEAD_BEEF, 64'hFF, 4'd3);
        exp_issues++;
        @(negedge clock);
        chk("c_c0_dreq", 64'(dcache_req_valid), 64'd0);
        next_cycle();
        head_ready_to_deq = 1'b0;
        dcache_req_ready  = 1'b1;
        @(negedge clock);
        chk("c_c1_dreq", 64'(dcache_req_valid), 64'd1);
        chk("c_c1_mreq", 64'(mmio_req_valid), 64'd0);
        chk("c_c1_busy", 64'(drain_busy), 64'd1);
        next_cycle();
        dcache_req_ready  = 1'b0;
        dcache_resp_valid = 1'b1;
        @(negedge clock);
        chk("c_c2_dreq", 64'(dcache_req_valid), 64'd0);
        chk("c_c2_issue", 64'(head_issuing), 64'd0);
        next_cycle();
        dcache_resp_valid = 1'b0;
        @(negedge clock);
        chk("c_c3_issue", 64'(head_issuing), 64'd1);
        chk("c_c3_busy", 64'(drain_busy), 64'd0);
        next_cycle();
        @(negedge clock);
        chk("c_c4_issue", 64'(head_issuing), 64'd0);

        // MMIO store with ready held low for 4 cycles, wrong-port responses ignored
        next_cycle();
        present(1'b1, 64'h1000_0000, 64'h0000_0000_1234_5678, 64'h0F, 4'd2);
        exp_issues++;
        next_cycle();
        head_ready_to_deq = 1'b0;
        head_store_addr   = 64'hFFFF_0000;
        dcache_resp_valid = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            chk("m_hold_mreq", 64'(mmio_req_valid), 64'd1);
            chk("m_hold_dreq", 64'(dcache_req_valid), 64'd0);
            chk("m_hold_addr", dcache_req_addr, 64'h1000_0000);
            chk("m_hold_data", dcache_req_data, 64'h1234_5678);
            next_cycle();
        end
        dcache_resp_valid = 1'b0;
        mmio_req_ready    = 1'b1;
        @(negedge clock);
        chk("m_c5_mreq", 64'(mmio_req_valid), 64'd1);
        next_cycle();
        mmio_req_ready    = 1'b0;
        dcache_resp_valid = 1'b1;
        @(negedge clock);
        chk("m_c6_busy", 64'(drain_busy), 64'd1);
        next_cycle();
        dcache_resp_valid = 1'b0;
        mmio_resp_valid   = 1'b1;
        @(negedge clock);
        chk("m_c7_issue", 64'(head_issuing), 64'd0);
        next_cycle();
        mmio_resp_valid = 1'b0;
        @(negedge clock);
        chk("m_c8_issue", 64'(head_issuing), 64'd1);
        next_cycle();

        // Back-to-back: two entries, ready and response always high
        dcache_req_ready  = 1'b1;
        dcache_resp_valid = 1'b1;
        present(1'b0, 64'h8000_0100, 64'hA5A5_0001, 64'hF0, 4'd2);
        exp_q.push_back({1'b0, 4'd1, 64'h8000_0200, 64'h5A5A_0002, 64'h0C});
        exp_issues += 2;
        pulses = 0;
        p1 = -1;
        p2 = -1;
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            logic seen;
            @(negedge clock);
            seen = head_issuing;
            if (seen) begin
                pulses++;
                if (pulses == 1) p1 = c;
                else p2 = c;
            end
            next_cycle();
            if (seen) begin
                idx++;
                if (idx == 1) begin
                    head_store_addr    = 64'h8000_0200;
                    head_store_data    = 64'h5A5A_0002;
                    head_store_mask    = 64'h0C;
                    head_store_ls_size = 4'd1;
                end else begin
                    head_ready_to_deq = 1'b0;
                end
            end
        end
        dcache_req_ready  = 1'b0;
        dcache_resp_valid = 1'b0;
        chk("b2b_pulses", 64'(pulses), 64'd2);
        chk("b2b_first", 64'(p1), 64'd3);
        chk("b2b_gap_ge3", 64'((p2 - p1) >= 3), 64'd1);

        // Reset while waiting for the response
        present(1'b0, 64'h8000_0300, 64'h1111_2222, 64'hFF, 4'd3);
        next_cycle();
        head_ready_to_deq = 1'b0;
        dcache_req_ready  = 1'b1;
        next_cycle();
        dcache_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("rm_busy", 64'(drain_busy), 64'd0);
        chk("rm_dreq", 64'(dcache_req_valid), 64'd0);
        chk("rm_issue", 64'(head_issuing), 64'd0);
        chk("rm_addr", dcache_req_addr, 64'd0);
        chk("rm_mask", dcache_req_mask, 64'd0);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        dcache_resp_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk("rm_stale_issue", 64'(head_issuing), 64'd0);
            chk("rm_stale_busy", 64'(drain_busy), 64'd0);
            next_cycle();
        end
        dcache_resp_valid = 1'b0;
        next_cycle();

        // Timeout behaviour: no response ever arrives
        present(1'b0, 64'h8000_0400, 64'h3333_4444, 64'h3F, 4'd3);
        next_cycle();
        head_ready_to_deq = 1'b0;
        dcache_req_ready  = 1'b1;
        next_cycle();
        dcache_req_ready = 1'b0;
`ifdef STORE_DRAIN_TIMEOUT_EN
        exp_issues++;
        pulse_cyc = -1;
        for (int c = 2; c < 40; c++) begin
            @(negedge clock);
            if (head_issuing) begin
                pulse_cyc = c;
                break;
            end
            next_cycle();
        end
        chk("tmo_pulse_cycle", 64'(pulse_cyc), 64'd10);
        chk("tmo_err", 64'(drain_err), 64'd1);
        next_cycle();
        @(negedge clock);
        chk("tmo_issue_one", 64'(head_issuing), 64'd0);
        chk("tmo_err_sticky", 64'(drain_err), 64'd1);
        next_cycle();
`else
        pulse_cyc = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            if (head_issuing) pulse_cyc++;
            next_cycle();
        end
        chk("notmo_pulses", 64'(pulse_cyc), 64'd0);
        chk("notmo_busy", 64'(drain_busy), 64'd1);
        chk("notmo_err", 64'(drain_err), 64'd0);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
`endif

        // Final scoreboard state
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        chk("issue_total", 64'(issue_cnt), 64'(exp_issues));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_drain.md
STORE_DRAIN -- requirements
Module: store_drain

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the number of response-wait cycles before a timeout fires (STORE_DRAIN_TIMEOUT_EN only).
REQ-002 SHALL have port clock, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port head_ready_to_deq, input, 1, store-queue head entry is valid and committed.
REQ-005 SHALL have port head_mmio, input, 1, head store targets MMIO space.
REQ-006 SHALL have ports head_store_addr, head_store_data and head_store_mask, input, 64 each (`SRC_RANGE), head payload.
REQ-007 SHALL have port head_store_ls_size, input, 4, head access size.
REQ-008 SHALL have port head_issuing, output, 1, one-cycle pulse that frees the head entry.
REQ-009 SHALL have ports dcache_req_valid (output, 1) and dcache_req_ready (input, 1), dcache write request handshake.
REQ-010 SHALL have ports dcache_req_addr, dcache_req_data and dcache_req_mask (output, 64 each) and dcache_req_size (output, 4), request payload.
REQ-011 SHALL have port dcache_resp_valid, input, 1, dcache write done.
REQ-012 SHALL have ports mmio_req_valid (output, 1), mmio_req_ready (input, 1) and mmio_resp_valid (input, 1); the MMIO port shares the dcache_req_* payload wires.
REQ-013 SHALL have port drain_busy, output, 1, high whenever the FSM is not IDLE.
REQ-014 SHALL have port drain_err, output, 1, sticky timeout flag.

Function
REQ-015 SHALL implement an FSM with three states: IDLE, REQ and WAIT_RESP.
REQ-016 In IDLE with head_ready_to_deq=1, the block SHALL latch the head payload and head_mmio into internal registers and move to REQ on the next edge.
REQ-017 Request outputs SHALL be driven only from the latched registers and SHALL be stable while in REQ.
REQ-018 In REQ, the block SHALL assert dcache_req_valid if the latched mmio bit is 0, otherwise mmio_req_valid; it SHALL never assert both.
REQ-019 The asserted request valid SHALL stay high until the matching ready is sampled high, then the FSM SHALL go to WAIT_RESP.
REQ-020 In WAIT_RESP, on the matching resp_valid, head_issuing SHALL pulse high for exactly that cycle and the FSM SHALL return to IDLE.
REQ-021 A response arriving on the non-matching port, or arriving outside WAIT_RESP, SHALL be ignored.
REQ-022 Minimum latency SHALL be 3 cycles from head_ready_to_deq to head_issuing: latch, then req accepted, then response.
REQ-023 The earliest next latch SHALL be the cycle after head_issuing, so the same entry is never issued twice.
REQ-024 The block SHALL have no flush input; committed stores always drain to completion.
REQ-025 head_ready_to_deq dropping while the FSM is in REQ or WAIT_RESP SHALL have no effect.
REQ-026 head_issuing SHALL be registered and SHALL not depend combinationally on dcache_resp_valid.

Reset
REQ-027 Asserting reset SHALL immediately force IDLE and clear all outputs and latched registers to 0, including in-flight requests; drain_err SHALL be 0.
REQ-028 After reset deassertion, the first latch SHALL occur no earlier than the first rising edge with reset low.

Configuration
REQ-029 With STORE_DRAIN_TIMEOUT_EN defined, an 8-bit counter SHALL clear on entry to WAIT_RESP and increment each WAIT_RESP cycle.
REQ-030 When that counter reaches TIMEOUT_CYCLES without a response, drain_err SHALL set, head_issuing SHALL pulse and the FSM SHALL return to IDLE; drain_err SHALL clear only on reset.
REQ-031 Without STORE_DRAIN_TIMEOUT_EN, the counter SHALL not exist, WAIT_RESP SHALL wait indefinitely and drain_err SHALL be tied to 0.

Verification
REQ-032 Cacheable store: head addr=0x8000_0010, data=0xDEAD_BEEF, mask=0xFF, size=3; ready and response each one cycle later -> dcache_req_valid in cycle 1, head_issuing in cycle 3, mmio_req_valid always 0.
REQ-033 MMIO store: head_mmio=1, addr=0x1000_0000; mmio_req_ready held low for 4 cycles -> mmio_req_valid held 4+ cycles with stable payload, dcache_req_valid 0.
REQ-034 Back-to-back: two committed entries presented continuously with ready/response always 1 -> exactly two head_issuing pulses, separated by at least 3 cycles.
REQ-035 Reset mid-flight: assert reset in WAIT_RESP -> all outputs 0 in the same cycle; a later stale dcache_resp_valid produces no head_issuing.
REQ-036 Timeout (macro defined, TIMEOUT_CYCLES=8): no response -> drain_err=1 and a head_issuing pulse after 8 WAIT_RESP cycles; without the macro, no pulse for 1000 cycles.
